// File: rtl/calc_seq.sv
// Sequencing controller for the calculator arithmetic path: true-form operands in,
// two's-complement execute, true-form result out with overflow saturation.
module calc_seq #(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_true,
    input  logic [W-1:0] b_true,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result_true,
    output logic         ovf
);

    localparam int unsigned RW = W + 1;
    localparam logic [RW-1:0] MAX_MAG = {2'b00, {(W - 1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CVT  = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t          state;
    logic [W-1:0]    a_lat;
    logic [W-1:0]    b_lat;
    logic [1:0]      op_lat;
    logic [W-1:0]    a_tc;
    logic [W-1:0]    b_tc;
    logic [RW-1:0]   r;

    logic [W-1:0]    a_cvt;
    logic [W-1:0]    b_cvt;
    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;
    logic [RW-1:0]   r_next;
    logic            r_neg;
    logic [RW-1:0]   r_abs;
    logic            r_ovf;
    logic [W-1:0]    r_true;

    // True form to two's complement; -0 collapses to 0 through the negation.
    function automatic logic [W-1:0] to_tc(input logic [W-1:0] t);
        logic [W-1:0] m;
        m = {1'b0, t[W-2:0]};
        return t[W-1] ? (~m + W'(1)) : m;
    endfunction

    // Conversion, execute and write-back datapath.
    always_comb begin
        a_cvt  = to_tc(a_lat);
        b_cvt  = to_tc(b_lat);
        a_ext  = {a_tc[W-1], a_tc};
        b_ext  = {b_tc[W-1], b_tc};
        r_next = '0;
        case (op_lat)
            2'b00:   r_next = a_ext + b_ext;
            2'b01:   r_next = a_ext - b_ext;
            2'b10:   r_next = a_ext;
            default: r_next = RW'(0) - a_ext;
        endcase
        r_neg  = r[RW-1];
        r_abs  = r_neg ? (~r + RW'(1)) : r;
        r_ovf  = (r_abs > MAX_MAG);
        r_true = r_ovf ? {r_neg, {(W - 1){1'b1}}} : {r_neg, r_abs[W-2:0]};
    end

    // Sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_lat       <= '0;
            b_lat       <= '0;
            op_lat      <= '0;
            a_tc        <= '0;
            b_tc        <= '0;
            r           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_true <= '0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat  <= a_true;
                        b_lat  <= b_true;
                        op_lat <= op;
                        busy   <= 1'b1;
                        state  <= CVT;
                    end
                end
                CVT: begin
                    a_tc  <= a_cvt;
                    b_tc  <= b_cvt;
                    state <= EXEC;
                end
                EXEC: begin
                    r     <= r_next;
                    state <= WB;
                end
                default: begin
                    result_true <= r_true;
                    ovf         <= r_ovf;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
